// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit of rv32Core.
//
// Owns the fetch PC and requests 128-bit (4-instruction) lines from
// instruction memory with a valid/ready handshake. Returned bundles go into
// a small circular fetch queue that feeds decode. A redirect flushes the
// queue, drops any response in flight and restarts fetch at the new PC.
//
// Parameters:
//   RESET_PC  byte address fetched first after reset
//   FQ_DEPTH  fetch-queue entries (power of 2, >= 2)
//
// Ports:
//   i_clk, i_resetn          clock, asynchronous active-low reset
//   o_imem_valid             read request to instruction memory
//   o_imem_raddr             line index (pc[IMEM_ADDRW+3:4])
//   i_imem_ready             response valid (only while o_imem_valid is high)
//   i_imem_rinst             line data, slot k = bits [32k+31:32k]
//   i_redirect, i_redirect_pc  flush and restart at i_redirect_pc
//   o_fq_valid, i_fq_ready   queue head handshake towards decode
//   o_fq_pc                  line-aligned PC of head bundle
//   o_fq_inst                head bundle
//   o_fq_mask                per-slot valid bits of head bundle
//
// Optional build macro IFU_STAT_EN adds:
//   o_stat_bundles           bundles enqueued (wraps mod 2^32)
//   o_stat_stall             IDLE cycles blocked by a full queue
//
// IMEM_ADDRW normally comes from configure.h; a default is supplied here.

`ifndef IMEM_ADDRW
`define IMEM_ADDRW 16
`endif

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    output logic                   o_imem_valid,
    output logic [`IMEM_ADDRW-1:0] o_imem_raddr,
    input  logic                   i_imem_ready,
    input  logic [127:0]           i_imem_rinst,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_pc,
    output logic                   o_fq_valid,
    input  logic                   i_fq_ready,
    output logic [31:0]            o_fq_pc,
    output logic [127:0]           o_fq_inst,
    output logic [3:0]             o_fq_mask
`ifdef IFU_STAT_EN
    ,
    output logic [31:0]            o_stat_bundles,
    output logic [31:0]            o_stat_stall
`endif
);

    localparam int unsigned AW = `IMEM_ADDRW;
    localparam int unsigned PW = $clog2(FQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [31:0]    pc;
    logic [31:0]    line_pc;
    logic [3:0]     line_mask;
    logic           inflight;
    logic [PW:0]    wptr, rptr;
    logic [PW:0]    count;
    logic [PW+1:0]  occupancy;
    logic           can_fetch;
    logic           enq, deq;

    logic [31:0]    fq_pc   [FQ_DEPTH];
    logic [127:0]   fq_inst [FQ_DEPTH];
    logic [3:0]     fq_mask [FQ_DEPTH];

    assign line_pc   = pc & 32'hFFFF_FFF0;
    // Slots below the entry word of the line are not part of the fetch stream.
    assign line_mask = 4'b1111 << pc[3:2];

    assign count     = wptr - rptr;
    // A slot is reserved from REQ until the response is enqueued, so a
    // response can always be accepted without checking for a full queue.
    assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
    assign can_fetch = occupancy < (PW+2)'(FQ_DEPTH);

    assign o_fq_valid = (wptr != rptr);
    assign enq = (state == RESP) && i_imem_ready && !i_redirect;
    assign deq = o_fq_valid && i_fq_ready && !i_redirect;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        if (i_redirect) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (can_fetch) state_nx = REQ;
                REQ:     state_nx = RESP;
                RESP:    if (i_imem_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Valid drops in IDLE between transactions so each ready pulse maps to
    // exactly one address.
    always_comb begin
        o_imem_valid = 1'b0;
        case (state)
            REQ, RESP: o_imem_valid = 1'b1;
            default:   o_imem_valid = 1'b0;
        endcase
    end

    // ---------------- PC, address and queue pointers ----------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            o_imem_raddr <= '0;
            wptr         <= '0;
            rptr         <= '0;
        end else if (i_redirect) begin
            pc       <= i_redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            if (state == IDLE && can_fetch) begin
                inflight     <= 1'b1;
                o_imem_raddr <= pc[AW+3:4];
            end
            if (enq) begin
                pc       <= line_pc + 32'd16;
                inflight <= 1'b0;
                wptr     <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // ---------------- Queue storage ----------------
    always_ff @(posedge i_clk) begin
        if (enq) begin
            fq_pc[wptr[PW-1:0]]   <= line_pc;
            fq_inst[wptr[PW-1:0]] <= i_imem_rinst;
            fq_mask[wptr[PW-1:0]] <= line_mask;
        end
    end

    always_comb begin
        o_fq_pc   = '0;
        o_fq_inst = '0;
        o_fq_mask = '0;
        if (o_fq_valid) begin
            o_fq_pc   = fq_pc[rptr[PW-1:0]];
            o_fq_inst = fq_inst[rptr[PW-1:0]];
            o_fq_mask = fq_mask[rptr[PW-1:0]];
        end
    end

`ifdef IFU_STAT_EN
    // ---------------- Statistics ----------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_stat_bundles <= '0;
            o_stat_stall   <= '0;
        end else begin
            if (enq) begin
                o_stat_bundles <= o_stat_bundles + 32'd1;
            end
            if (state == IDLE && !can_fetch) begin
                o_stat_stall <= o_stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: transaction-level reference model, per-cycle
// compare, directed literal checks plus randomized decode back-pressure,
// redirects and resets.

`ifndef IMEM_ADDRW
`define IMEM_ADDRW 16
`endif

module tb_inst_fetch;

    localparam int unsigned AW    = `IMEM_ADDRW;
    localparam int unsigned DEPTH = 4;

    logic                   i_clk;
    logic                   i_resetn;
    logic                   o_imem_valid;
    logic [`IMEM_ADDRW-1:0] o_imem_raddr;
    logic                   i_imem_ready;
    logic [127:0]           i_imem_rinst;
    logic                   i_redirect;
    logic [31:0]            i_redirect_pc;
    logic                   o_fq_valid;
    logic                   i_fq_ready;
    logic [31:0]            o_fq_pc;
    logic [127:0]           o_fq_inst;
    logic [3:0]             o_fq_mask;
`ifdef IFU_STAT_EN
    logic [31:0]            o_stat_bundles;
    logic [31:0]            o_stat_stall;
`endif

    inst_fetch #(
        .RESET_PC (32'h0000_0100),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .o_imem_valid  (o_imem_valid),
        .o_imem_raddr  (o_imem_raddr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rinst  (i_imem_rinst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fq_valid    (o_fq_valid),
        .i_fq_ready    (i_fq_ready),
        .o_fq_pc       (o_fq_pc),
        .o_fq_inst     (o_fq_inst),
        .o_fq_mask     (o_fq_mask)
`ifdef IFU_STAT_EN
        ,
        .o_stat_bundles(o_stat_bundles),
        .o_stat_stall  (o_stat_stall)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: deterministic function of the line index.
    function automatic logic [127:0] data_fn(input logic [31:0] a);
        return {a * 32'h9E37_79B9, a ^ 32'hA5A5_5A5A, ~a, a + 32'h0000_1234};
    endfunction

    function automatic logic [31:0] line_idx(input logic [31:0] p);
        return (p >> 4) & ((32'd1 << AW) - 32'd1);
    endfunction

    function automatic logic [3:0] mask_of(input logic [31:0] p);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'((p >> 2) & 32'd3)) m[k] = 1'b1;
        end
        return m;
    endfunction

    // ---------------- Memory responder ----------------
    logic vprev = 1'b0;
    always @(posedge i_clk) begin
        vprev        <= o_imem_valid;
        i_imem_rinst <= data_fn(32'(o_imem_raddr));
    end
    assign i_imem_ready = o_imem_valid && vprev;

    // ---------------- Reference model ----------------
    // A fetch started from an idle cycle occupies the memory port for two
    // cycles (request, response) and its bundle is visible the cycle after.
    typedef struct {
        logic [31:0]  pc;
        logic [127:0] inst;
        logic [3:0]   mask;
    } bundle_t;

    bundle_t     mq[$];
    logic [31:0] m_pc      = 32'h0000_0100;
    int          m_busy    = 0;
    logic [31:0] m_raddr   = '0;
    logic [31:0] m_bundles = '0;
    logic [31:0] m_stall   = '0;

    always @(posedge i_clk) begin
        int pre;
        bundle_t b;
        if (!i_resetn) begin
            mq.delete();
            m_pc      = 32'h0000_0100;
            m_busy    = 0;
            m_raddr   = '0;
            m_bundles = '0;
            m_stall   = '0;
        end else begin
            pre = mq.size();
            if (m_busy == 0 && pre >= DEPTH) m_stall = m_stall + 32'd1;
            if (i_redirect) begin
                mq.delete();
                m_busy = 0;
                m_pc   = i_redirect_pc & ~32'd3;
            end else begin
                if (pre > 0 && i_fq_ready) void'(mq.pop_front());
                if (m_busy == 2) begin
                    m_busy = 1;
                end else if (m_busy == 1) begin
                    b.pc   = m_pc & ~32'hF;
                    b.inst = data_fn(line_idx(m_pc));
                    b.mask = mask_of(m_pc);
                    mq.push_back(b);
                    m_bundles = m_bundles + 32'd1;
                    m_pc   = (m_pc & ~32'hF) + 32'd16;
                    m_busy = 0;
                end else if (pre < DEPTH) begin
                    m_busy  = 2;
                    m_raddr = line_idx(m_pc);
                end
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge i_clk) begin
        if (!i_resetn) begin
            chk("rst_imem_valid", 128'(o_imem_valid), 128'(0));
            chk("rst_imem_raddr", 128'(o_imem_raddr), 128'(0));
            chk("rst_fq_valid",   128'(o_fq_valid),   128'(0));
            chk("rst_fq_pc",      128'(o_fq_pc),      128'(0));
            chk("rst_fq_inst",    o_fq_inst,          128'(0));
            chk("rst_fq_mask",    128'(o_fq_mask),    128'(0));
        end else begin
            chk("imem_valid", 128'(o_imem_valid), 128'(m_busy != 0));
            if (m_busy != 0) chk("imem_raddr", 128'(o_imem_raddr), 128'(m_raddr));
            chk("fq_valid", 128'(o_fq_valid), 128'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("fq_pc",   128'(o_fq_pc),   128'(mq[0].pc));
                chk("fq_inst", o_fq_inst,       mq[0].inst);
                chk("fq_mask", 128'(o_fq_mask), 128'(mq[0].mask));
            end else begin
                chk("fq_pc_zero",   128'(o_fq_pc),   128'(0));
                chk("fq_inst_zero", o_fq_inst,       128'(0));
                chk("fq_mask_zero", 128'(o_fq_mask), 128'(0));
            end
        end
`ifdef IFU_STAT_EN
        chk("stat_bundles", 128'(o_stat_bundles), 128'(m_bundles));
        chk("stat_stall",   128'(o_stat_stall),   128'(m_stall));
`endif
    end

    // ---------------- Stimulus and literal checks ----------------
    task automatic tick();
        @(negedge i_clk);
    endtask

    initial begin
        int   found;
        int   rst_cnt;
        int   rdy_pct;
        logic [31:0] all_ones;
`ifdef IFU_STAT_EN
        logic [31:0] s0;
`endif
        i_resetn      = 1'b0;
        i_fq_ready    = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        all_ones      = (32'd1 << AW) - 32'd1;

        // Reset release and first-fetch timing from RESET_PC=0x100.
        repeat (3) tick();
        #1 i_resetn = 1'b1;
        tick();
        chk("c1_valid", 128'(o_imem_valid), 128'(1));
        chk("c1_raddr", 128'(o_imem_raddr), 128'(32'h10));
        tick();
        chk("c2_ready", 128'(i_imem_ready), 128'(1));
        chk("c2_fq_valid", 128'(o_fq_valid), 128'(0));
        tick();
        chk("c3_fq_valid", 128'(o_fq_valid), 128'(1));
        chk("c3_fq_pc",    128'(o_fq_pc),    128'(32'h100));
        chk("c3_fq_mask",  128'(o_fq_mask),  128'(4'b1111));
        chk("c3_fq_inst",  o_fq_inst,        data_fn(32'h10));
        tick();
        chk("c4_raddr", 128'(o_imem_raddr), 128'(32'h11));

        // Queue fills with decode stalled, then drains in order.
        #1 i_resetn = 1'b0;
        i_fq_ready = 1'b0;
        repeat (2) tick();
        #1 i_resetn = 1'b1;
        repeat (20) tick();
        chk("full_valid_low", 128'(o_imem_valid), 128'(0));
        chk("full_head_pc",   128'(o_fq_pc),      128'(32'h100));
`ifdef IFU_STAT_EN
        s0 = o_stat_stall;
        repeat (10) tick();
        chk("stall_plus10",  128'(o_stat_stall),   128'(s0 + 32'd10));
        chk("bundles_eq4",   128'(o_stat_bundles), 128'(4));
`endif
        #1 i_fq_ready = 1'b1;
        tick(); chk("drain_pc1", 128'(o_fq_pc), 128'(32'h110));
        tick(); chk("drain_pc2", 128'(o_fq_pc), 128'(32'h120));
        tick(); chk("drain_pc3", 128'(o_fq_pc), 128'(32'h130));
        tick(); chk("drain_pc4", 128'(o_fq_pc), 128'(32'h140));

        // Redirect during a ready response.
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (o_imem_valid && i_imem_ready) found = 1;
            else tick();
        end
        chk("resp_found", 128'(found), 128'(1));
        #1 i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0204;
        tick();
        #1 i_redirect = 1'b0;
        chk("redir_flushed", 128'(o_fq_valid),   128'(0));
        chk("redir_idle",    128'(o_imem_valid), 128'(0));
        tick();
        chk("redir_raddr", 128'(o_imem_raddr), 128'(32'h20));
        tick();
        tick();
        chk("redir_pc",   128'(o_fq_pc),   128'(32'h200));
        chk("redir_mask", 128'(o_fq_mask), 128'(4'b1110));

        // PC and line address wrap.
        #1 i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF0;
        tick();
        #1 i_redirect = 1'b0;
        tick();
        chk("wrap_raddr_top", 128'(o_imem_raddr), 128'(all_ones));
        tick();
        tick();
        chk("wrap_pc_top", 128'(o_fq_pc), 128'(32'hFFFF_FFF0));
        tick();
        chk("wrap_raddr0", 128'(o_imem_raddr), 128'(0));
        chk("wrap_valid",  128'(o_imem_valid), 128'(1));
        tick();
        tick();
        chk("wrap_pc0", 128'(o_fq_pc), 128'(0));

        // Randomized back-pressure, redirects and resets.
        rst_cnt = 0;
        rdy_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) rdy_pct = 10 + 20 * int'($urandom_range(0, 4));
            tick();
            #1;
            i_fq_ready = ($urandom_range(0, 99) < rdy_pct);
            i_redirect = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 2))
                0:       i_redirect_pc = $urandom;
                1:       i_redirect_pc = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
                default: i_redirect_pc = 32'($urandom_range(0, 1023));
            endcase
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) i_resetn = 1'b1;
            end else if ($urandom_range(0, 999) < 3) begin
                i_resetn = 1'b0;
                rst_cnt  = 2;
            end
        end
        #1 i_resetn = 1'b1;
        i_redirect = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
